control_seq: RTL and testbench

CONTROL_SEQ -- requirements
Module: control_seq

---
 rtl/control_seq_if.sv | 38 +++
 rtl/control_seq.sv | 165 ++++++++++++++++
 tb/tb_control_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/control_seq_if.sv
// Instruction handshake, status inputs and decode strobes between the issuing
// core and the control sequencer.
interface control_seq_if #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned FN_W  = 4,
  parameter int unsigned CNT_W = 32
);
  logic             ir_valid;
  logic             ir_ready;
  logic [OP_W-1:0]  opcode;
  logic [FN_W-1:0]  opfunc;
  logic             adata_zero;
  logic             mem_ack;
  logic             regs_we;
  logic             ram_we;
  logic             ram_rd;
  logic             d_or_b;
  logic             branch;
  logic             branch_ind;
  logic             imm16;
  logic             pc_we;
  logic [FN_W-1:0]  alu_func;
  logic             illegal;
  logic             fault;
  logic [CNT_W-1:0] retired;

  modport master (
    output ir_valid, opcode, opfunc, adata_zero, mem_ack,
    input  ir_ready, regs_we, ram_we, ram_rd, d_or_b, branch, branch_ind,
           imm16, pc_we, alu_func, illegal, fault, retired
  );

  modport slave (
    input  ir_valid, opcode, opfunc, adata_zero, mem_ack,
    output ir_ready, regs_we, ram_we, ram_rd, d_or_b, branch, branch_ind,
           imm16, pc_we, alu_func, illegal, fault, retired
  );
endinterface

// File: rtl/control_seq.sv
// Multi-cycle instruction sequencer: latches one instruction per handshake and
// steps it through EXEC / MEM / WB, with memory timeout and retired counter.
module control_seq #(
  parameter int unsigned    OP_W        = 4,
  parameter int unsigned    FN_W        = 4,
  parameter logic [FN_W-1:0] ALU_MEM_FN = FN_W'(4'b0010),
  parameter int unsigned    MEM_TIMEOUT = 15,
  parameter int unsigned    CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  control_seq_if.slave bus
);
  localparam int unsigned TO_W = 8;
  // Fault fires on the MEM_TIMEOUT-th MEM cycle that has no ack.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  localparam logic [OP_W-1:0] OP_ALU  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ALUI = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BRI  = OP_W'(5);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_e;

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [FN_W-1:0]  fn_q, fn_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic ir_ready, regs_we, ram_we, ram_rd, d_or_b, branch, branch_ind;
  logic imm16, pc_we, illegal, fault, taken, is_ld, is_st;
  logic [FN_W-1:0] alu_func;

  assign is_ld = (op_q == OP_LD);
  assign is_st = (op_q == OP_ST);
  assign taken = (fn_q[0] & bus.adata_zero) | (fn_q[1] & ~bus.adata_zero);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      fn_q      <= '0;
      cnt_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  // Next state and register updates
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    fn_d      = fn_q;
    cnt_d     = cnt_q;
    retired_d = retired_q + CNT_W'(pc_we);
    case (state_q)
      IDLE: begin
        if (bus.ir_valid) begin
          op_d    = bus.opcode;
          fn_d    = bus.opfunc;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d   = '0;
        state_d = (is_ld || is_st) ? MEM : IDLE;
      end
      MEM: begin
        if (bus.mem_ack) begin
          state_d = is_ld ? WB : IDLE;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode outputs from latched instruction and state
  always_comb begin
    ir_ready   = 1'b0;
    regs_we    = 1'b0;
    ram_we     = 1'b0;
    ram_rd     = 1'b0;
    d_or_b     = 1'b0;
    branch     = 1'b0;
    branch_ind = 1'b0;
    imm16      = 1'b0;
    pc_we      = 1'b0;
    illegal    = 1'b0;
    fault      = 1'b0;
    alu_func   = '0;
    if (state_q != IDLE) begin
      imm16    = (op_q != OP_ALU);
      d_or_b   = (op_q == OP_ALUI) || is_ld || (op_q == OP_BR);
      alu_func = (is_ld || is_st) ? ALU_MEM_FN : fn_q;
    end
    case (state_q)
      IDLE: ir_ready = ~reset;
      EXEC: begin
        case (op_q)
          OP_ALU, OP_ALUI: begin
            regs_we = 1'b1;
            pc_we   = 1'b1;
          end
          OP_BR, OP_BRI: begin
            branch     = (op_q == OP_BR) & taken;
            branch_ind = (op_q == OP_BRI) & taken;
            regs_we    = taken & fn_q[3];
            pc_we      = 1'b1;
          end
          OP_LD: ram_rd = 1'b1;
          OP_ST: ram_we = 1'b1;
          default: begin
            illegal = 1'b1;
            pc_we   = 1'b1;
          end
        endcase
      end
      MEM: begin
        if (bus.mem_ack) begin
          ram_rd = is_ld;
          ram_we = is_st;
          pc_we  = is_st;
        end else if (cnt_q == TO_LAST) begin
          fault = 1'b1;
        end else begin
          ram_rd = is_ld;
          ram_we = is_st;
        end
      end
      WB: begin
        regs_we = 1'b1;
        pc_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ir_ready   = ir_ready;
  assign bus.regs_we    = regs_we;
  assign bus.ram_we     = ram_we;
  assign bus.ram_rd     = ram_rd;
  assign bus.d_or_b     = d_or_b;
  assign bus.branch     = branch;
  assign bus.branch_ind = branch_ind;
  assign bus.imm16      = imm16;
  assign bus.pc_we      = pc_we;
  assign bus.alu_func   = alu_func;
  assign bus.illegal    = illegal;
  assign bus.fault      = fault;
  assign bus.retired    = retired_q;
endmodule

// File: tb/tb_control_seq.sv
// Directed self-checking bench for control_seq: vector table for single-cycle
// ops plus hand sequences for memory, timeout, reset and counter wrap.
module tb_control_seq;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_ret = 0;

  always #5 clk = ~clk;

  control_seq_if #(.OP_W(4), .FN_W(4), .CNT_W(32)) bus ();
  control_seq_if #(.OP_W(4), .FN_W(4), .CNT_W(4))  bus4 ();

  assign bus4.ir_valid   = bus.ir_valid;
  assign bus4.opcode     = bus.opcode;
  assign bus4.opfunc     = bus.opfunc;
  assign bus4.adata_zero = bus.adata_zero;
  assign bus4.mem_ack    = bus.mem_ack;

  control_seq #(.OP_W(4), .FN_W(4), .CNT_W(32)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  control_seq #(.OP_W(4), .FN_W(4), .CNT_W(4))  u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // {ir_ready, regs_we, ram_we, ram_rd, d_or_b, branch, branch_ind, imm16, pc_we, illegal, fault, alu_func}
  function automatic logic [14:0] outs();
    return {bus.ir_ready, bus.regs_we, bus.ram_we, bus.ram_rd, bus.d_or_b, bus.branch,
            bus.branch_ind, bus.imm16, bus.pc_we, bus.illegal, bus.fault, bus.alu_func};
  endfunction

  function automatic logic [14:0] ex(input logic rdy, input logic rw, input logic rwe,
                                     input logic rrd, input logic dob, input logic br,
                                     input logic bri, input logic imm, input logic pc,
                                     input logic ill, input logic flt, input logic [3:0] alu);
    return {rdy, rw, rwe, rrd, dob, br, bri, imm, pc, ill, flt, alu};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [3:0]  fn;
    logic        az;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[10];
  logic [14:0] idle_e, ld_exec, ld_wb, st_exec, st_ack, st_fault;

  // Handshake one instruction from IDLE and leave the DUT in EXEC.
  task automatic issue(input logic [3:0] op, input logic [3:0] fn);
    bus.ir_valid = 1'b1;
    bus.opcode   = op;
    bus.opfunc   = fn;
    #1;
    chk("handshake_idle", 32'(outs()), 32'(idle_e));
    tick();
    bus.ir_valid = 1'b0;
    bus.opcode   = ~op;
    bus.opfunc   = ~fn;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int high;
    idle_e   = ex(1,0,0,0,0,0,0,0,0,0,0,4'h0);
    ld_exec  = ex(0,0,0,1,1,0,0,1,0,0,0,4'h2);
    ld_wb    = ex(0,1,0,0,1,0,0,1,1,0,0,4'h2);
    st_exec  = ex(0,0,1,0,0,0,0,1,0,0,0,4'h2);
    st_ack   = ex(0,0,1,0,0,0,0,1,1,0,0,4'h2);
    st_fault = ex(0,0,0,0,0,0,0,1,0,0,1,4'h2);
    vecs[0] = '{"alu",        4'd0,  4'h5, 1'b0, ex(0,1,0,0,0,0,0,0,1,0,0,4'h5)};
    vecs[1] = '{"alui",       4'd1,  4'h3, 1'b0, ex(0,1,0,0,1,0,0,1,1,0,0,4'h3)};
    vecs[2] = '{"br_z_link",  4'd4,  4'h9, 1'b1, ex(0,1,0,0,1,1,0,1,1,0,0,4'h9)};
    vecs[3] = '{"br_nz_not",  4'd4,  4'h9, 1'b0, ex(0,0,0,0,1,0,0,1,1,0,0,4'h9)};
    vecs[4] = '{"bri_nz",     4'd5,  4'hA, 1'b0, ex(0,1,0,0,0,0,1,1,1,0,0,4'hA)};
    vecs[5] = '{"bri_not",    4'd5,  4'h2, 1'b1, ex(0,0,0,0,0,0,0,1,1,0,0,4'h2)};
    vecs[6] = '{"br_nolink",  4'd4,  4'h3, 1'b0, ex(0,0,0,0,1,1,0,1,1,0,0,4'h3)};
    vecs[7] = '{"ill_7",      4'd7,  4'h6, 1'b0, ex(0,0,0,0,0,0,0,1,1,1,0,4'h6)};
    vecs[8] = '{"ill_15",     4'd15, 4'h0, 1'b0, ex(0,0,0,0,0,0,0,1,1,1,0,4'h0)};
    vecs[9] = '{"ill_6",      4'd6,  4'hF, 1'b1, ex(0,0,0,0,0,0,0,1,1,1,0,4'hF)};

    reset = 1'b1;
    bus.ir_valid = 1'b1; bus.opcode = 4'd0; bus.opfunc = 4'd5;
    bus.adata_zero = 1'b0; bus.mem_ack = 1'b0;
    #3;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_retired", bus.retired, 32'd0);
    tick(); tick();
    bus.ir_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("post_reset_idle", 32'(outs()), 32'(idle_e));
    tick(); tick();
    chk("idle_hold", 32'(outs()), 32'(idle_e));

    foreach (vecs[i]) begin
      bus.adata_zero = ~vecs[i].az;
      issue(vecs[i].op, vecs[i].fn);
      bus.adata_zero = vecs[i].az;
      #1;
      chk({vecs[i].name, "_exec"}, 32'(outs()), 32'(vecs[i].exp));
      exp_ret++;
      tick();
      chk({vecs[i].name, "_back_idle"}, 32'(outs()), 32'(idle_e));
      chk({vecs[i].name, "_retired"}, bus.retired, 32'(exp_ret));
    end

    // Load, ack on third MEM cycle
    issue(4'd2, 4'd7);
    chk("ld_exec", 32'(outs()), 32'(ld_exec));
    tick(); chk("ld_mem1", 32'(outs()), 32'(ld_exec));
    tick(); chk("ld_mem2", 32'(outs()), 32'(ld_exec));
    tick(); bus.mem_ack = 1'b1; #1;
    chk("ld_mem3_ack", 32'(outs()), 32'(ld_exec));
    tick(); bus.mem_ack = 1'b0; #1;
    chk("ld_wb", 32'(outs()), 32'(ld_wb));
    exp_ret++;
    tick();
    chk("ld_back_idle", 32'(outs()), 32'(idle_e));
    chk("ld_retired", bus.retired, 32'(exp_ret));

    // Store, ack on first MEM cycle
    issue(4'd3, 4'd4);
    chk("st_exec", 32'(outs()), 32'(st_exec));
    tick(); bus.mem_ack = 1'b1; #1;
    chk("st_ack", 32'(outs()), 32'(st_ack));
    exp_ret++;
    tick(); bus.mem_ack = 1'b0; #1;
    chk("st_back_idle", 32'(outs()), 32'(idle_e));
    chk("st_retired", bus.retired, 32'(exp_ret));

    // Store with no ack: timeout fault
    issue(4'd3, 4'd1);
    high = 0;
    for (int i = 0; i < 40 && !bus.fault; i++) begin
      if (bus.ram_we) high++;
      tick();
    end
    chk("to_fault_seen", 32'(bus.fault), 32'd1);
    chk("to_fault_outs", 32'(outs()), 32'(st_fault));
    chk("to_ram_we_cycles", 32'(high), 32'd15);
    tick();
    chk("to_back_idle", 32'(outs()), 32'(idle_e));
    chk("to_retired", bus.retired, 32'(exp_ret));

    // Load with ack exactly on the timeout cycle: ack wins
    issue(4'd2, 4'd0);
    for (int i = 0; i < 15; i++) tick();
    bus.mem_ack = 1'b1; #1;
    chk("ackwin_mem15", 32'(outs()), 32'(ld_exec));
    tick(); bus.mem_ack = 1'b0; #1;
    chk("ackwin_wb", 32'(outs()), 32'(ld_wb));
    exp_ret++;
    tick();
    chk("ackwin_retired", bus.retired, 32'(exp_ret));

    // Reset in the middle of a MEM access
    issue(4'd2, 4'd0);
    tick();
    reset = 1'b1; #1;
    chk("midrst_outs", 32'(outs()), 32'd0);
    chk("midrst_retired", bus.retired, 32'd0);
    exp_ret = 0;
    tick(); tick();
    reset = 1'b0; #1;
    chk("midrst_idle", 32'(outs()), 32'(idle_e));
    tick();
    chk("midrst_no_retire", bus.retired, 32'd0);

    // 17 retirements: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      issue(4'd0, 4'd1);
      exp_ret++;
      tick();
    end
    chk("wrap_cnt32", bus.retired, 32'(exp_ret));
    chk("wrap_cnt4", 32'(bus4.retired), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
